// File: rtl/tl_cntr_timed.sv
// -----------------------------------------------------------------------------
// tl_cntr_timed
//
// Two-street traffic-light controller. It is a four-phase Moore FSM with a
// minimum green time, a fixed yellow time and a pedestrian request latch.
//
//   S0 : A green , B red      S1 : A yellow, B red
//   S2 : A red   , B green    S3 : A red   , B yellow
//
// A green phase ends once it has lasted MIN_GREEN cycles and either its
// street's sensor reads "no cars" or a pedestrian request is pending. A yellow
// phase always lasts exactly YELLOW_CYC cycles.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   Ta, Tb   in   traffic sensors for street A / B (1 = cars present)
//   ped_req  in   pedestrian button (level or pulse), sampled every cycle
//   La, Lb   out  lamps: 2'b00 green, 2'b01 yellow, 2'b10 red
//   state    out  current phase (S0=00 .. S3=11)
//   ped_ack  out  one-cycle pulse on entry to a yellow phase that serves a
//                 pending pedestrian request
// -----------------------------------------------------------------------------
module tl_cntr_timed #(
    parameter int unsigned MIN_GREEN  = 10,  // 1..255
    parameter int unsigned YELLOW_CYC = 4    // 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [1:0] state,
    output logic       ped_ack
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;

    // Counter values on which a phase may end: cnt counts from 0 on the first
    // cycle of a phase, so reaching N-1 means the phase has been shown N cycles.
    localparam logic [7:0] GREEN_LAST  = 8'(MIN_GREEN - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ped_pend_q, ped_pend_d;
    logic       ped_ack_q, ped_ack_d;
    logic [1:0] la_q, la_d;
    logic [1:0] lb_q, lb_d;
    logic       state_chg;
    logic       enter_yellow;

    // Lamp pair for a phase. Only one street is ever non-red.
    function automatic logic [3:0] lamps_of(input state_t s);
        logic [3:0] l;
        unique case (s)
            S0:      l = {LAMP_GREEN,  LAMP_RED};
            S1:      l = {LAMP_YELLOW, LAMP_RED};
            S2:      l = {LAMP_RED,    LAMP_GREEN};
            default: l = {LAMP_RED,    LAMP_YELLOW};
        endcase
        return l;
    endfunction

    // Next-state logic.
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S0: if ((!Ta || ped_pend_q) && cnt_q >= GREEN_LAST)  state_d = S1;
            S1: if (cnt_q == YELLOW_LAST)                         state_d = S2;
            S2: if ((!Tb || ped_pend_q) && cnt_q >= GREEN_LAST)  state_d = S3;
            default: if (cnt_q == YELLOW_LAST)                    state_d = S0;
        endcase

        state_chg    = (state_d != state_q);
        enter_yellow = state_chg && (state_d == S1 || state_d == S3);

        // Saturating phase counter; saturation never forces an exit.
        if (state_chg)
            cnt_d = 8'd0;
        else if (cnt_q == 8'hFF)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 8'd1;

        // A request arriving on the clearing edge keeps the latch set.
        ped_pend_d = ped_req | (ped_pend_q & ~enter_yellow);
        ped_ack_d  = enter_yellow & ped_pend_q;

        // Lamps are registered from the next state, so they change on the
        // same edge as state and have no combinational path from the inputs.
        {la_d, lb_d} = lamps_of(state_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S0;
            cnt_q      <= 8'd0;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
            la_q       <= LAMP_GREEN;
            lb_q       <= LAMP_RED;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            ped_ack_q  <= ped_ack_d;
            la_q       <= la_d;
            lb_q       <= lb_d;
        end
    end

    assign state   = state_q;
    assign La      = la_q;
    assign Lb      = lb_q;
    assign ped_ack = ped_ack_q;

endmodule

// File: tb/tb_tl_cntr_timed.sv
// -----------------------------------------------------------------------------
// tb_tl_cntr_timed
//
// Scoreboard bench for tl_cntr_timed. The driver applies inputs on the falling
// edge, steps a phase-level reference model (phase index, cycles shown so far,
// pending flag) and queues the outputs expected after the next rising edge.
// A separate monitor pops one entry per rising edge and compares.
// -----------------------------------------------------------------------------
module tb_tl_cntr_timed;

    localparam int MIN_GREEN  = 10;
    localparam int YELLOW_CYC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       Ta, Tb, ped_req;
    logic [1:0] La, Lb, state;
    logic       ped_ack;

    tl_cntr_timed #(
        .MIN_GREEN (MIN_GREEN),
        .YELLOW_CYC(YELLOW_CYC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Ta     (Ta),
        .Tb     (Tb),
        .ped_req(ped_req),
        .La     (La),
        .Lb     (Lb),
        .state  (state),
        .ped_ack(ped_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] la;
        logic [1:0] lb;
        logic       ack;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which phase is shown, for how many cycles it has been
    // shown (1 on its first cycle), and whether a pedestrian is waiting.
    int m_phase;
    int m_age;
    bit m_pend;
    bit m_ack;

    // Lamp colours per phase: 0 green, 1 yellow, 2 red.
    logic [1:0] la_of [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [1:0] lb_of [4] = '{2'd2, 2'd2, 2'd0, 2'd1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input bit rst, input bit ta, input bit tb, input bit pr);
        bit green, sensor, leave, to_yellow;
        if (rst) begin
            m_phase = 0;
            m_age   = 1;
            m_pend  = 1'b0;
            m_ack   = 1'b0;
            return;
        end
        green  = (m_phase == 0 || m_phase == 2);
        sensor = (m_phase == 0) ? ta : tb;
        if (green)
            leave = (!sensor || m_pend) && (m_age >= MIN_GREEN);
        else
            leave = (m_age == YELLOW_CYC);
        to_yellow = leave && green;  // a green phase always hands over to yellow
        m_ack     = to_yellow && m_pend;
        m_pend    = pr || (m_pend && !to_yellow);
        if (leave) begin
            m_phase = (m_phase + 1) % 4;
            m_age   = 1;
        end else begin
            m_age++;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.st  = 2'(m_phase);
        e.la  = la_of[m_phase];
        e.lb  = lb_of[m_phase];
        e.ack = m_ack;
        sb_q.push_back(e);
    endtask

    task automatic cycle(input bit rst, input bit ta, input bit tb, input bit pr);
        @(negedge clk);
        reset   = rst;
        Ta      = ta;
        Tb      = tb;
        ped_req = pr;
        model_edge(rst, ta, tb, pr);
        push_expected();
    endtask

    task automatic run(input int n, input bit ta, input bit tb, input bit pr);
        repeat (n) cycle(1'b0, ta, tb, pr);
    endtask

    task automatic do_reset();
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset between clock edges and confirm it takes effect at once.
    task automatic async_reset_mid_phase();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_state", state, 2'b00);
        check("async_La", La, 2'b00);
        check("async_Lb", Lb, 2'b10);
        check("async_ack", ped_ack, 1'b0);
        model_edge(1'b1, Ta, Tb, ped_req);
        push_expected();
    endtask

    // Monitor: the outputs are presented every cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("state", state, e.st);
            check("La", La, e.la);
            check("Lb", Lb, e.lb);
            check("ped_ack", ped_ack, e.ack);
            check("no_conflict", (La != 2'b10 && Lb != 2'b10), 1'b0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        Ta      = 1'b0;
        Tb      = 1'b0;
        ped_req = 1'b0;
        model_edge(1'b1, 1'b0, 1'b0, 1'b0);

        // Cars always on A: hold S0.
        do_reset();
        run(50, 1'b1, 1'b0, 1'b0);

        // A empty, B busy: S0(10) S1(4) then S2 held.
        do_reset();
        run(40, 1'b0, 1'b1, 1'b0);

        // Both empty: full loop repeating.
        do_reset();
        run(60, 1'b0, 1'b0, 1'b0);

        // Pedestrian pulse while A is busy.
        do_reset();
        run(3, 1'b1, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0, 1'b1);
        run(20, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of yellow, then a full green again.
        do_reset();
        run(12, 1'b0, 1'b0, 1'b0);
        async_reset_mid_phase();
        run(20, 1'b0, 1'b0, 1'b0);

        // Pedestrian held through yellow entries; both streets busy.
        do_reset();
        run(40, 1'b1, 1'b1, 1'b1);
        run(20, 1'b1, 1'b1, 1'b0);

        // Counter saturation while A stays busy, then release.
        do_reset();
        run(300, 1'b1, 1'b1, 1'b0);
        run(20, 1'b0, 1'b1, 1'b0);

        // Randomized traffic, pedestrians and occasional resets.
        do_reset();
        repeat (3000) begin
            bit r_rst, r_ta, r_tb, r_pr;
            r_rst = ($urandom_range(0, 499) == 0);
            r_ta  = ($urandom_range(0, 3) != 0);
            r_tb  = ($urandom_range(0, 3) != 0);
            r_pr  = ($urandom_range(0, 24) == 0);
            cycle(r_rst, r_ta, r_tb, r_pr);
        end

        @(posedge clk);
        #3;
        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tl_cntr_timed.md
TL_CNTR_TIMED -- requirements
Module: tl_cntr_timed

Interface
REQ-001 Parameter MIN_GREEN, default 10: minimum cycles a green phase SHALL hold; legal range 1..255.
REQ-002 Parameter YELLOW_CYC, default 4: exact cycles a yellow phase SHALL last; legal range 1..255.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Ta  input  1  street A traffic sensor; 1 = cars present on A.
REQ-006 Tb  input  1  street B traffic sensor; 1 = cars present on B.
REQ-007 ped_req  input  1  pedestrian button, level or pulse; sampled every cycle.
REQ-008 La  output  2  street A lamp: 2'b00 green, 2'b01 yellow, 2'b10 red.
REQ-009 Lb  output  2  street B lamp, same encoding as La.
REQ-010 state  output  2  current phase, S0=00, S1=01, S2=10, S3=11.
REQ-011 ped_ack  output  1  one-cycle pulse when a pending pedestrian request is served.

Function
REQ-012 Four-state Moore FSM SHALL be used: S0 A green/B red, S1 A yellow/B red, S2 A red/B green, S3 A red/B yellow.
REQ-013 La, Lb SHALL be decoded from registered state only (no combinational path from Ta, Tb, ped_req).
REQ-014 8-bit phase counter cnt SHALL clear to 0 on every state change and otherwise increment by 1 per cycle, saturating at 255.
REQ-015 S0->S1 SHALL occur when (Ta==0 or ped_pend==1) and cnt >= MIN_GREEN-1; else remain S0.
REQ-016 S1->S2 SHALL occur when cnt == YELLOW_CYC-1, regardless of Ta, Tb, ped_req.
REQ-017 S2->S3 SHALL occur when (Tb==0 or ped_pend==1) and cnt >= MIN_GREEN-1; else remain S2.
REQ-018 S3->S0 SHALL occur when cnt == YELLOW_CYC-1, regardless of inputs.
REQ-019 With ped_pend==0 the S0/S2 exits SHALL match the base next-state equations (d1 = q1^q0; d0 = ~q1&~q0&~Ta | q1&~q0&~Tb), gated by the minimum-green condition.
REQ-020 ped_pend register SHALL set on any cycle with ped_req==1 and clear on the cycle the FSM enters S1 or S3.
REQ-021 ped_ack SHALL be 1 for exactly the first cycle of S1 or S3 when ped_pend was 1 on the transition edge; 0 otherwise.
REQ-022 ped_req==1 on the same edge that clears ped_pend SHALL leave ped_pend set (set wins).
REQ-023 Green exit SHALL be evaluated on the edge where cnt reaches MIN_GREEN-1, giving green duration exactly MIN_GREEN cycles when the exit condition is already true.
REQ-024 Yellow duration SHALL be exactly YELLOW_CYC cycles.
REQ-025 Sensor held continuously at 1 (Ta in S0, Tb in S2) with no ped_pend SHALL hold green indefinitely; cnt saturation SHALL not cause a transition.
REQ-026 Both lamps SHALL never be green or yellow simultaneously in any reachable state.

Reset
REQ-027 reset==1 SHALL asynchronously force state=S0, cnt=0, ped_pend=0, ped_ack=0, La=2'b00, Lb=2'b10.
REQ-028 Reset asserted mid-phase (including mid-yellow) SHALL abort the phase immediately; after release, operation restarts at S0 with full MIN_GREEN.
REQ-029 First state update after reset deassertion SHALL occur on the next rising clk edge.

Verification
REQ-030 Reset, Ta=1, Tb=0 for 50 cycles -> state stays S0, La=00, Lb=10 throughout.
REQ-031 Defaults, Ta=0 from reset, Tb=1 -> S0 for 10 cycles, S1 for 4, then S2 held while Tb=1; La=10, Lb=00.
REQ-032 Full loop with Ta=0, Tb=0 -> state sequence S0(10) S1(4) S2(10) S3(4) S0, repeating.
REQ-033 Ta=1, 1-cycle ped_req pulse at cycle 3 -> S1 entered at cycle 10, ped_ack=1 for that one cycle, ped_pend=0 afterwards.
REQ-034 reset pulsed at cycle 2 of S1 -> immediate S0, La=00, Lb=10, cnt=0; next exit not before 10 more cycles.
REQ-035 ped_req held at 1 across an S1 entry -> ped_ack pulses once, ped_pend stays 1, S2 ends after MIN_GREEN despite Tb=1.
